id_stage_pipe: RTL and testbench

//  Parametrised decode stage: register file + decode + registered ID/EX pipeline latch. Sits between IF and EX.

---
 rtl/id_stage_pipe.sv | 167 ++++++++++++++++
 tb/tb_id_stage_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS-style decode stage with register file, operand read,
// control decode and a registered ID/EX latch behind a valid/ready handshake.
// Handles load-use interlock, flush, and WB bypass at capture and while holding.
// Optional feature: define ID_STALL_CNT_EN to add stall_cnt / bubble_cnt.
module id_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int REG_NUM  = 32,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     ins,
  input  logic [XLEN-1:0] npc_i,
  input  logic            wb_en,
  input  logic [4:0]      wb_reg,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_dst_reg,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      op,
  output logic [5:0]      func,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [XLEN-1:0] data_a,
  output logic [XLEN-1:0] data_b,
  output logic [4:0]      data_write_reg,
  output logic [XLEN-1:0] simm,
  output logic [XLEN-1:0] zimm,
  output logic [25:0]     jpc,
  output logic [XLEN-1:0] npc_o,
  output logic            if_reg_write,
  output logic            if_mem_read,
  output logic            if_mem_write
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     bubble_cnt
`endif
);

  localparam int AW = $clog2(REG_NUM);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20, OP_LW   = 6'h23, OP_SB   = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [XLEN-1:0] regs [REG_NUM];

  // A register index is writable if it exists and is not the hardwired zero.
  function automatic logic writable(input logic [4:0] f);
    return (int'(f) < REG_NUM) && !((ZERO_REG != 0) && (f == 5'd0));
  endfunction

  logic [4:0] rs_f, rt_f;
  logic       wb_write;
  logic       dec_rw, dec_mr, dec_mw, uses_rs, uses_rt, hazard, accept;
  logic [4:0] dec_dst;
  logic [XLEN-1:0] rd_a, rd_b, cap_a, cap_b;

  assign rs_f     = ins[25:21];
  assign rt_f     = ins[20:16];
  assign wb_write = wb_en && writable(wb_reg);

  // Control decode of the incoming instruction.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    dec_rw  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_dst = 5'd0;
    uses_rs = 1'b1;
    uses_rt = 1'b0;
    unique case (ins[31:26])
      OP_RTYPE: begin dec_rw = 1'b1; dec_dst = ins[15:11]; uses_rt = 1'b1; end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
        dec_rw = 1'b1; dec_dst = rt_f;
      end
      OP_LUI:       begin dec_rw = 1'b1; dec_dst = rt_f; uses_rs = 1'b0; end
      OP_LW, OP_LB: begin dec_rw = 1'b1; dec_mr = 1'b1; dec_dst = rt_f; end
      OP_SW, OP_SB: begin dec_mw = 1'b1; uses_rt = 1'b1; end
      OP_BEQ, OP_BNE: uses_rt = 1'b1;
      OP_J:         uses_rs = 1'b0;
      OP_JAL:       begin dec_rw = 1'b1; dec_dst = 5'd31; uses_rs = 1'b0; end
      default:      ;  // BGTZ and unknown opcodes: no side effects
    endcase
  end

  // Operand read with writeback bypass so a same-cycle write is seen.
  always_comb begin
    rd_a = writable(rs_f) ? regs[rs_f[AW-1:0]] : '0;
    rd_b = writable(rt_f) ? regs[rt_f[AW-1:0]] : '0;
    cap_a = (wb_write && wb_reg == rs_f) ? wb_data : rd_a;
    cap_b = (wb_write && wb_reg == rt_f) ? wb_data : rd_b;
  end

  assign hazard = in_valid && ex_mem_read && (ex_dst_reg != 5'd0) &&
                  ((uses_rs && ex_dst_reg == rs_f) || (uses_rt && ex_dst_reg == rt_f));
  assign in_ready = rst && (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Register file write port; runs regardless of stall or flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the register file is reset entry by entry because the stage
      // promises every register reads 0 after reset; this rules out a RAM macro.
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (wb_write) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      regs[wb_reg[AW-1:0]] <= wb_data;
    end
  end

  // ID/EX latch: flush > accept > drain; holding latch tracks WB to rs/rt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0; op <= '0; func <= '0; rs <= '0; rt <= '0;
      data_a <= '0; data_b <= '0; data_write_reg <= '0; simm <= '0; zimm <= '0;
      jpc <= '0; npc_o <= '0; if_reg_write <= 1'b0; if_mem_read <= 1'b0;
      if_mem_write <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      op             <= ins[31:26];
      func           <= ins[5:0];
      rs             <= rs_f;
      rt             <= rt_f;
      data_a         <= cap_a;
      data_b         <= cap_b;
      data_write_reg <= dec_dst;
      simm           <= {{(XLEN-16){ins[15]}}, ins[15:0]};
      zimm           <= {{(XLEN-16){1'b0}}, ins[15:0]};
      jpc            <= ins[25:0];
      npc_o          <= npc_i;
      if_reg_write   <= dec_rw;
      if_mem_read    <= dec_mr;
      if_mem_write   <= dec_mw;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      if (wb_write && wb_reg == rs) data_a <= wb_data;
      if (wb_write && wb_reg == rt) data_b <= wb_data;
    end
  end

`ifdef ID_STALL_CNT_EN
  // Saturating stall and bubble counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (in_valid && !in_ready && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (hazard && bubble_cnt != 32'hFFFF_FFFF) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: two instances (32 regs with hardwired r0, and
// 16 regs with ordinary r0) driven in lockstep, checked against a
// transaction-level model of the stage. Directed steps, then random traffic.
module tb_id_stage_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, wb_en, ex_mem_read, flush, out_ready;
  logic [31:0] ins, npc_i, wb_data;
  logic [4:0]  wb_reg, ex_dst_reg;

  logic        in_ready [2], out_valid [2], if_rw [2], if_mr [2], if_mw [2];
  logic [5:0]  op_o [2], func_o [2];
  logic [4:0]  rs_o [2], rt_o [2], dwr_o [2];
  logic [31:0] da_o [2], db_o [2], simm_o [2], zimm_o [2], npc_o [2];
  logic [25:0] jpc_o [2];
`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_o [2], bubble_o [2];
`endif

  id_stage_pipe #(.XLEN(32), .REG_NUM(32), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .ins(ins),
    .npc_i(npc_i), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_dst_reg(ex_dst_reg), .flush(flush),
    .out_valid(out_valid[0]), .out_ready(out_ready), .op(op_o[0]), .func(func_o[0]),
    .rs(rs_o[0]), .rt(rt_o[0]), .data_a(da_o[0]), .data_b(db_o[0]),
    .data_write_reg(dwr_o[0]), .simm(simm_o[0]), .zimm(zimm_o[0]), .jpc(jpc_o[0]),
    .npc_o(npc_o[0]), .if_reg_write(if_rw[0]), .if_mem_read(if_mr[0]),
    .if_mem_write(if_mw[0])
`ifdef ID_STALL_CNT_EN
    , .stall_cnt(stall_o[0]), .bubble_cnt(bubble_o[0])
`endif
  );

  id_stage_pipe #(.XLEN(32), .REG_NUM(16), .ZERO_REG(0)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .ins(ins),
    .npc_i(npc_i), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_dst_reg(ex_dst_reg), .flush(flush),
    .out_valid(out_valid[1]), .out_ready(out_ready), .op(op_o[1]), .func(func_o[1]),
    .rs(rs_o[1]), .rt(rt_o[1]), .data_a(da_o[1]), .data_b(db_o[1]),
    .data_write_reg(dwr_o[1]), .simm(simm_o[1]), .zimm(zimm_o[1]), .jpc(jpc_o[1]),
    .npc_o(npc_o[1]), .if_reg_write(if_rw[1]), .if_mem_read(if_mr[1]),
    .if_mem_write(if_mw[1])
`ifdef ID_STALL_CNT_EN
    , .stall_cnt(stall_o[1]), .bubble_cnt(bubble_o[1])
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic rw, mr, mw, urs, urt;
    logic [4:0] dst;
  } dec_t;

  typedef struct {
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, dst;
    logic [31:0] da [2];
    logic [31:0] db [2];
    logic [31:0] simm, zimm, npc;
    logic [25:0] jpc;
    logic        rw, mr, mw;
  } lat_t;

  int          nregs [2] = '{32, 16};
  bit          zr    [2] = '{1'b1, 1'b0};
  logic [31:0] mregs [2][32];
  lat_t        m;
  bit          m_valid;
  longint      m_stall, m_bubble;

  function automatic dec_t decode(input logic [31:0] w);
    dec_t d = '{rw: 1'b0, mr: 1'b0, mw: 1'b0, urs: 1'b1, urt: 1'b0, dst: 5'd0};
    case (w[31:26])
      6'h00:                      begin d.rw = 1; d.dst = w[15:11]; d.urt = 1; end
      6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E: begin d.rw = 1; d.dst = w[20:16]; end
      6'h0F:                      begin d.rw = 1; d.dst = w[20:16]; d.urs = 0; end
      6'h23, 6'h20:               begin d.rw = 1; d.mr = 1; d.dst = w[20:16]; end
      6'h2B, 6'h28:               begin d.mw = 1; d.urt = 1; end
      6'h04, 6'h05:               d.urt = 1;
      6'h02:                      d.urs = 0;
      6'h03:                      begin d.rw = 1; d.dst = 5'd31; d.urs = 0; end
      default:                    ;
    endcase
    return d;
  endfunction

  function automatic bit tb_writable(input int i, input logic [4:0] r);
    return (int'(r) < nregs[i]) && !(zr[i] && r == 5'd0);
  endfunction

  function automatic logic [31:0] tb_read(input int i, input logic [4:0] r);
    return tb_writable(i, r) ? mregs[i][r] : 32'd0;
  endfunction

  function automatic bit model_hazard();
    dec_t d = decode(ins);
    return in_valid && ex_mem_read && ex_dst_reg != 0 &&
           ((d.urs && ex_dst_reg == ins[25:21]) || (d.urt && ex_dst_reg == ins[20:16]));
  endfunction

  function automatic bit model_ready();
    return (!m_valid || out_ready) && !model_hazard();
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) for (int r = 0; r < 32; r++) mregs[i][r] = '0;
    m_valid = 0; m_stall = 0; m_bubble = 0;
  endtask

  // One clock edge of the stage, evaluated from the inputs present at the edge.
  // Operands are defined as register values after this edge's writeback.
  task automatic model_clock();
    bit   hz  = model_hazard();
    bit   rdy = model_ready();
    dec_t d   = decode(ins);
    if (in_valid && !rdy && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (hz && m_bubble < 64'hFFFF_FFFF) m_bubble++;
    for (int i = 0; i < 2; i++)
      if (wb_en && tb_writable(i, wb_reg)) mregs[i][wb_reg] = wb_data;
    if (flush) m_valid = 0;
    else if (in_valid && rdy) begin
      m_valid = 1;
      m.op = ins[31:26]; m.func = ins[5:0]; m.rs = ins[25:21]; m.rt = ins[20:16];
      m.dst = d.rw ? d.dst : 5'd0; m.rw = d.rw; m.mr = d.mr; m.mw = d.mw;
      m.simm = 32'(signed'(ins[15:0])); m.zimm = {16'd0, ins[15:0]};
      m.jpc = ins[25:0]; m.npc = npc_i;
      for (int i = 0; i < 2; i++) begin
        m.da[i] = tb_read(i, m.rs);
        m.db[i] = tb_read(i, m.rt);
      end
    end else if (out_ready) m_valid = 0;
    else if (m_valid && wb_en) begin
      for (int i = 0; i < 2; i++) begin
        if (tb_writable(i, wb_reg) && wb_reg == m.rs) m.da[i] = wb_data;
        if (tb_writable(i, wb_reg) && wb_reg == m.rt) m.db[i] = wb_data;
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("out_valid%0d", i), out_valid[i], m_valid);
      if (m_valid) begin
        check($sformatf("op%0d", i), op_o[i], m.op);
        check($sformatf("func%0d", i), func_o[i], m.func);
        check($sformatf("rs%0d", i), rs_o[i], m.rs);
        check($sformatf("rt%0d", i), rt_o[i], m.rt);
        check($sformatf("data_a%0d", i), da_o[i], m.da[i]);
        check($sformatf("data_b%0d", i), db_o[i], m.db[i]);
        check($sformatf("dst%0d", i), dwr_o[i], m.dst);
        check($sformatf("simm%0d", i), simm_o[i], m.simm);
        check($sformatf("zimm%0d", i), zimm_o[i], m.zimm);
        check($sformatf("jpc%0d", i), jpc_o[i], m.jpc);
        check($sformatf("npc%0d", i), npc_o[i], m.npc);
        check($sformatf("ctl%0d", i), {if_rw[i], if_mr[i], if_mw[i]}, {m.rw, m.mr, m.mw});
      end
`ifdef ID_STALL_CNT_EN
      check($sformatf("stall_cnt%0d", i), stall_o[i], m_stall);
      check($sformatf("bubble_cnt%0d", i), bubble_o[i], m_bubble);
`endif
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_in_ready"}, in_ready[i], 1'b0);
      check({tag, "_out_valid"}, out_valid[i], 1'b0);
      check({tag, "_fields"}, {op_o[i], func_o[i], rs_o[i], rt_o[i], dwr_o[i], jpc_o[i]}, '0);
      check({tag, "_data"}, {da_o[i], db_o[i]}, '0);
      check({tag, "_imm_npc"}, {simm_o[i] | zimm_o[i] | npc_o[i]}, '0);
      check({tag, "_ctl"}, {if_rw[i], if_mr[i], if_mw[i]}, '0);
`ifdef ID_STALL_CNT_EN
      check({tag, "_cnt"}, {stall_o[i], bubble_o[i]}, '0);
`endif
    end
  endtask

  // Check in_ready before the edge, clock the model, check outputs after it.
  task automatic step();
    #1;
    for (int i = 0; i < 2; i++) check($sformatf("in_ready%0d", i), in_ready[i], model_ready());
    @(posedge clk);
    model_clock();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    in_valid = 0; ins = '0; npc_i = '0; wb_en = 0; wb_reg = '0; wb_data = '0;
    ex_mem_read = 0; ex_dst_reg = '0; flush = 0; out_ready = 1;
  endtask

  function automatic logic [31:0] rand_ins();
    logic [5:0] ops [16] = '{6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23,
                             6'h20, 6'h2B, 6'h28, 6'h04, 6'h05, 6'h07, 6'h02, 6'h03};
    logic [5:0] o   = ($urandom_range(0, 16) == 16) ? 6'h11 : ops[$urandom_range(0, 15)];
    logic [4:0] r_s = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
    logic [4:0] r_t = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
    return {o, r_s, r_t, 16'($urandom)};
  endfunction

  longint s0, b0;

  initial begin
    // Reset with busy inputs: nothing may be written or captured.
    rst = 0; idle();
    in_valid = 1; ins = 32'h2001_0005; wb_en = 1; wb_reg = 5'd3; wb_data = 32'hABCD;
    model_reset();
    #12;
    check_reset_state("reset");
    idle();
    rst = 1;
    step();

    // ADDI r1,r0,5 with r1=5 written the same cycle.
    in_valid = 1; ins = 32'h2001_0005; npc_i = 32'h104;
    wb_en = 1; wb_reg = 5'd1; wb_data = 32'd5;
    step();
    check("addi_data_b", db_o[0], 32'd5);
    check("addi_dst", dwr_o[0], 5'd1);
    check("addi_reg_write", if_rw[0], 1'b1);
    check("addi_simm", simm_o[0], 32'd5);

    idle(); wb_en = 1; wb_reg = 5'd2; wb_data = 32'h1234; step();
    idle(); wb_en = 1; wb_reg = 5'd4; wb_data = 32'h55; step();

    // Load-use on r2: ADD r3,r2,r4 stalls one cycle, then issues.
    idle(); in_valid = 1; ins = 32'h0044_1820; npc_i = 32'h200;
    ex_mem_read = 1; ex_dst_reg = 5'd2;
    step();
    check("hazard_bubble", out_valid[0], 1'b0);
    ex_mem_read = 0;
    step();
    check("hazard_issue_valid", out_valid[0], 1'b1);
    check("hazard_issue_a", da_o[0], 32'h1234);
    check("hazard_issue_b", db_o[0], 32'h55);
    check("hazard_issue_dst", dwr_o[0], 5'd3);

    // Backpressure 3 cycles with r2 rewritten while held.
    idle(); in_valid = 1; ins = 32'h0044_2820; npc_i = 32'h204; step();
    in_valid = 1; ins = 32'h34A6_0007; npc_i = 32'h208; out_ready = 0;
    wb_en = 1; wb_reg = 5'd2; wb_data = 32'hDEAD;
    step();
    wb_en = 0;
    step();
    step();
    check("hold_in_ready", in_ready[0], 1'b0);
    check("hold_data_a", da_o[0], 32'hDEAD);
    check("hold_npc", npc_o[0], 32'h204);

    // Flush while the latch is full and a handshake occurs.
    out_ready = 1; flush = 1; step();
    check("flush_valid", out_valid[0], 1'b0);
    idle(); step();

    // r0 behaviour and out-of-range index on the 16-register instance.
    idle(); wb_en = 1; wb_reg = 5'd0; wb_data = 32'hFFFF; step();
    idle(); wb_en = 1; wb_reg = 5'd20; wb_data = 32'h777; step();
    idle(); in_valid = 1; ins = 32'h0014_3020; npc_i = 32'h300; step();
    check("r0_zero_reg", da_o[0], 32'd0);
    check("r0_ordinary", da_o[1], 32'hFFFF);
    check("r20_in_range", db_o[0], 32'h777);
    check("r20_out_of_range", db_o[1], 32'd0);

    // Four hazard cycles then two backpressure cycles.
    s0 = m_stall; b0 = m_bubble;
    idle(); in_valid = 1; ins = 32'h0044_1820; ex_mem_read = 1; ex_dst_reg = 5'd4;
    repeat (4) step();
    ex_mem_read = 0; step();
    out_ready = 0; ins = 32'h2001_0001;
    repeat (2) step();
    check("bubble_delta", m_bubble - b0, 4);
    check("stall_delta", m_stall - s0, 6);
`ifdef ID_STALL_CNT_EN
    check("bubble_cnt_delta", 64'(bubble_o[0]) - b0, 4);
    check("stall_cnt_delta", 64'(stall_o[0]) - s0, 6);
`endif

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      ins         = rand_ins();
      npc_i       = $urandom;
      wb_en       = $urandom_range(0, 1);
      wb_reg      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      ex_mem_read = ($urandom_range(0, 3) == 0);
      ex_dst_reg  = 5'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 15) == 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      step();
    end

    // Reset in the middle of operation: latch full, instruction in flight.
    idle(); in_valid = 1; ins = 32'h2001_0009; out_ready = 1; step();
    out_ready = 0; in_valid = 1;
    #2 rst = 0;
    #1 check_reset_state("midreset");
    model_reset();
    idle();
    #3 rst = 1;
    step();
    check("after_reset_in_ready", in_ready[0], 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
